// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-channel stability counter for slide switches.
// Optional edge pulses (sw_rise/sw_fall/sw_change) are built when SW_DEBOUNCE_EDGE_PULSE_EN is defined.
module sw_debounce #(
    parameter int clk_freq    = 50_000_000,
    parameter int DEBOUNCE_US = 10_000,
    parameter int NUM_SW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_change
);

    localparam int STABLE_CYCLES = clk_freq / 1_000_000 * DEBOUNCE_US;
    localparam int CNT_W         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_cfg
        $error("sw_debounce: STABLE_CYCLES must be at least 1");
    end

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [CNT_W-1:0]  cnt [NUM_SW];
    logic [NUM_SW-1:0] upd;

    // A channel updates when the synchronized level differs and has held for the full count.
    always_comb begin
        upd = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            upd[i] = (sync2[i] != sw_db[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sw_db <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync2[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    sw_db[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
    // Pulses are registered on the same edge that updates sw_db.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_rise   <= '0;
            sw_fall   <= '0;
            sw_change <= 1'b0;
        end else begin
            sw_rise   <= upd & sync2;
            sw_fall   <= upd & ~sync2;
            sw_change <= |upd;
        end
    end
`else
    assign sw_rise   = '0;
    assign sw_fall   = '0;
    assign sw_change = 1'b0;
`endif

endmodule
